// File: rtl/ariane_regfile_lol.sv
// Flip-flop based integer register file: 32 words, N combinational read ports,
// M clocked write ports, optional hardwired-zero word 0.
module ariane_regfile_lol #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter bit          ZERO_REG_ZERO  = 1'b0,
  localparam int unsigned NUM_WORDS     = 32,
  localparam int unsigned ADDR_WIDTH    = 5
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        test_en,
  input  logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]    raddr,
  output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]    rdata,
  input  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]   waddr,
  input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]   wdata,
  input  logic [NR_WRITE_PORTS-1:0]                   we
);

  logic [DATA_WIDTH-1:0] r_mem      [NUM_WORDS];
  logic [DATA_WIDTH-1:0] w_mem_next [NUM_WORDS];

  // test_en only exists for pin compatibility with the latch-based variant
  logic w_unused_test_en;
  assign w_unused_test_en = test_en;

  // Next-state of the array; ports are applied in index order so the highest enabled port wins
  always_comb begin
    w_mem_next = r_mem;
    for (int unsigned p = 0; p < NR_WRITE_PORTS; p++) begin
      if (we[p] && !(ZERO_REG_ZERO && (waddr[p] == ADDR_WIDTH'(0)))) begin
        w_mem_next[waddr[p]] = wdata[p];
      end
    end
  end

  // Storage update; reset clears every word and overrides any same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        r_mem[i] <= DATA_WIDTH'(0);
      end
    end else begin
      r_mem <= w_mem_next;
    end
  end

  // Zero-latency read ports, no write bypass; word 0 masked when hardwired to zero
  always_comb begin
    rdata = '0;
    for (int unsigned r = 0; r < NR_READ_PORTS; r++) begin
      if (ZERO_REG_ZERO && (raddr[r] == ADDR_WIDTH'(0))) begin
        rdata[r] = DATA_WIDTH'(0);
      end else begin
        rdata[r] = r_mem[raddr[r]];
      end
    end
  end

endmodule

// File: tb/tb_ariane_regfile_lol.sv
// Directed bench for ariane_regfile_lol; one instance per ZERO_REG_ZERO setting,
// both driven by the same stimulus.
module tb_ariane_regfile_lol;

  logic             clk = 1'b0;
  logic             rst;
  logic             test_en;
  logic [1:0][4:0]  raddr;
  logic [1:0][4:0]  waddr;
  logic [1:0][31:0] wdata;
  logic [1:0]       we;
  logic [1:0][31:0] rdata_z0;
  logic [1:0][31:0] rdata_z1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ariane_regfile_lol #(
    .DATA_WIDTH(32), .NR_READ_PORTS(2), .NR_WRITE_PORTS(2), .ZERO_REG_ZERO(1'b0)
  ) u_dut_z0 (
    .clk(clk), .rst(rst), .test_en(test_en), .raddr(raddr), .rdata(rdata_z0),
    .waddr(waddr), .wdata(wdata), .we(we)
  );

  ariane_regfile_lol #(
    .DATA_WIDTH(32), .NR_READ_PORTS(2), .NR_WRITE_PORTS(2), .ZERO_REG_ZERO(1'b1)
  ) u_dut_z1 (
    .clk(clk), .rst(rst), .test_en(test_en), .raddr(raddr), .rdata(rdata_z1),
    .waddr(waddr), .wdata(wdata), .we(we)
  );

  // Single comparison point: count and report
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write cycle on both ports, enables cleared afterwards
  task automatic wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                    input logic [4:0] a1, input logic [31:0] d1);
    waddr[0] = a0; wdata[0] = d0;
    waddr[1] = a1; wdata[1] = d1;
    we = en;
    tick();
    we = 2'b00;
  endtask

  // Read one address on both ports of both instances
  task automatic rd_check(input string tag, input logic [4:0] a,
                          input logic [31:0] exp_z0, input logic [31:0] exp_z1);
    raddr[0] = a;
    raddr[1] = a;
    #1;
    check({tag, "_z0_p0"}, rdata_z0[0], exp_z0);
    check({tag, "_z0_p1"}, rdata_z0[1], exp_z0);
    check({tag, "_z1_p0"}, rdata_z1[0], exp_z1);
    check({tag, "_z1_p1"}, rdata_z1[1], exp_z1);
  endtask

  // Sweep every address with the two ports in opposite order, expecting zero
  task automatic all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      raddr[0] = 5'(a);
      raddr[1] = 5'(31 - a);
      #1;
      check({tag, "_z0_p0"}, rdata_z0[0], 32'h0);
      check({tag, "_z0_p1"}, rdata_z0[1], 32'h0);
      check({tag, "_z1_p0"}, rdata_z1[0], 32'h0);
      check({tag, "_z1_p1"}, rdata_z1[1], 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1; test_en = 1'b0; we = 2'b00;
    raddr = '0; waddr = '0; wdata = '0;
    tick();
    rst = 1'b0;
    all_zero("reset");

    // Word 0 writable only when not hardwired
    wr(2'b01, 5'd0, 32'd10, 5'd0, 32'd0);
    rd_check("w0_write", 5'd0, 32'd10, 32'd0);

    // Reset clears previously written data; then a fresh write shows on every port
    rst = 1'b1;
    tick();
    rst = 1'b0;
    all_zero("rereset");
    wr(2'b01, 5'd1, 32'd20, 5'd0, 32'd0);
    rd_check("reg1", 5'd1, 32'd20, 32'd20);

    // Hardwired zero vs ordinary word 0, plus a parallel write elsewhere
    wr(2'b11, 5'd0, 32'hDEAD, 5'd5, 32'hBEEF);
    rd_check("zero_w", 5'd0, 32'hDEAD, 32'h0);
    rd_check("addr5", 5'd5, 32'hBEEF, 32'hBEEF);
    wr(2'b10, 5'd0, 32'h0, 5'd0, 32'h1234);
    rd_check("zero_p1", 5'd0, 32'h1234, 32'h0);

    // Same-address conflict: higher port wins
    wr(2'b11, 5'd7, 32'h11, 5'd7, 32'h22);
    rd_check("conflict", 5'd7, 32'h22, 32'h22);
    // Disabled port aimed at the same address must not interfere
    wr(2'b01, 5'd7, 32'h33, 5'd7, 32'h99);
    rd_check("dis_port", 5'd7, 32'h33, 32'h33);
    wr(2'b11, 5'd3, 32'hA, 5'd4, 32'hB);
    rd_check("dual3", 5'd3, 32'hA, 32'hA);
    rd_check("dual4", 5'd4, 32'hB, 32'hB);
    // Fully disabled cycle with junk on address/data leaves state alone
    wr(2'b00, 5'd3, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF);
    rd_check("no_we3", 5'd3, 32'hA, 32'hA);
    rd_check("no_we4", 5'd4, 32'hB, 32'hB);

    // No bypass: old value before the edge, new value after
    wr(2'b01, 5'd9, 32'h5, 5'd0, 32'h0);
    waddr[0] = 5'd9; wdata[0] = 32'h6; we = 2'b01;
    rd_check("nobyp_pre", 5'd9, 32'h5, 32'h5);
    tick();
    we = 2'b00;
    rd_check("nobyp_post", 5'd9, 32'h6, 32'h6);

    // Reset beats writes in the same cycle
    rst = 1'b1;
    waddr[0] = 5'd9; wdata[0] = 32'h77;
    waddr[1] = 5'd12; wdata[1] = 32'h88;
    we = 2'b11;
    tick();
    rst = 1'b0; we = 2'b00;
    rd_check("rst_we9", 5'd9, 32'h0, 32'h0);
    rd_check("rst_we12", 5'd12, 32'h0, 32'h0);
    rd_check("rst_we7", 5'd7, 32'h0, 32'h0);

    // test_en has no functional effect
    wr(2'b01, 5'd2, 32'h55, 5'd0, 32'h0);
    test_en = 1'b1;
    rd_check("ten_hi", 5'd2, 32'h55, 32'h55);
    tick();
    rd_check("ten_hi_clk", 5'd2, 32'h55, 32'h55);
    test_en = 1'b0;
    tick();
    rd_check("ten_lo", 5'd2, 32'h55, 32'h55);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
